// File: rtl/mig_tt_sim.sv
// mig_tt_sim: sequential majority-inverter-graph evaluator.
// A program of up to MAX_GATES three-input majority gates (each operand with
// an optional complement) is evaluated one gate per cycle over full NIN-input
// truth tables, and the truth table of one selected node is returned.
// Node numbering: 0 = constant 0, 1..NIN = projections x0..x(NIN-1),
// NIN+1+g = gate g.
// Optional feature macro: MIG_SIM_NPN_EN adds in_neg, which complements
// selected projections for the duration of a run.
module mig_tt_sim #(
  parameter int NIN       = 4,
  parameter int MAX_GATES = 16,
  parameter int IDXW      = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [$clog2(MAX_GATES)-1:0]      cfg_addr,
  input  logic [3*(IDXW+1)-1:0]             cfg_wdata,
  input  logic [$clog2(MAX_GATES+1)-1:0]    num_gates,
  input  logic [IDXW-1:0]                   out_sel,
  input  logic                              out_inv,
`ifdef MIG_SIM_NPN_EN
  input  logic [NIN-1:0]                    in_neg,
`endif
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [(2**NIN)-1:0]               tt_out
);

  localparam int TTW   = 2**NIN;
  localparam int AW    = $clog2(MAX_GATES);
  localparam int NGW   = $clog2(MAX_GATES+1);
  localparam int OPW   = IDXW + 1;
  localparam int NNODE = 1 + NIN + MAX_GATES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [3*OPW-1:0] prog    [MAX_GATES];
  logic [TTW-1:0]   gate_tt [MAX_GATES];
  logic [TTW-1:0]   node_tt [NNODE];

  logic [NGW-1:0]  k_q;
  logic [NGW-1:0]  ng_q;
  logic [IDXW-1:0] sel_q;
  logic            inv_q;
  logic [NIN-1:0]  neg_q;
  logic            err_q;
  logic            rej_q;
  logic [TTW-1:0]  tt_q;

  logic            accept;
  logic            reject;
  logic            too_many;
  logic            last_gate;
  logic            gate_bad;
  logic            gate_wr;
  logic            sel_bad;
  logic            err_fin;
  logic [3*OPW-1:0] cur;
  logic [TTW-1:0]  opv [3];
  logic [TTW-1:0]  maj;
  logic [TTW-1:0]  sel_tt;
  logic [TTW-1:0]  fin_tt;

  // Program memory: written only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready) begin
      prog[cfg_addr] <= cfg_wdata;
    end
  end

  // Flat view of every node's truth table: constant, projections, gates.
  always_comb begin
    for (int unsigned n = 0; n < NNODE; n++) begin
      node_tt[n] = '0;
    end
    for (int unsigned i = 0; i < NIN; i++) begin
      for (int unsigned m = 0; m < TTW; m++) begin
        node_tt[1+i][m] = (((m >> i) & 1) != 0) ^ neg_q[i];
      end
    end
    for (int unsigned g = 0; g < MAX_GATES; g++) begin
      node_tt[1+NIN+g] = gate_tt[g];
    end
  end

  // Current gate: fetch operands, apply complements, check ordering, vote.
  always_comb begin
    cur      = prog[k_q[AW-1:0]];
    gate_bad = 1'b0;
    for (int unsigned o = 0; o < 3; o++) begin
      opv[o] = '0;
      for (int unsigned n = 0; n < NNODE; n++) begin
        if (32'(cur[o*OPW +: IDXW]) == n) begin
          opv[o] = node_tt[n];
        end
      end
      opv[o] = opv[o] ^ {TTW{cur[o*OPW + IDXW]}};
      // Only constants, projections and strictly earlier gates are legal.
      if (32'(cur[o*OPW +: IDXW]) >= NIN + 1 + 32'(k_q)) begin
        gate_bad = 1'b1;
      end
    end
    maj     = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);
    gate_wr = (state_q == S_RUN) && !gate_bad;
  end

  // Gate node registers, one per program slot.
  for (genvar g = 0; g < MAX_GATES; g++) begin : g_node
    logic [TTW-1:0] r;
    // Capture gate g's table in the cycle it is evaluated.
    always_ff @(posedge clk) begin
      if (rst) begin
        r <= '0;
      end else if (gate_wr && (32'(k_q) == g)) begin
        r <= maj;
      end
    end
    assign gate_tt[g] = r;
  end

  // Result selection for the FIN cycle.
  always_comb begin
    sel_tt = '0;
    for (int unsigned n = 0; n < NNODE; n++) begin
      if (32'(sel_q) == n) begin
        sel_tt = node_tt[n];
      end
    end
    sel_bad = 32'(sel_q) >= NIN + 1 + 32'(ng_q);
    err_fin = err_q | sel_bad;
    fin_tt  = err_fin ? '0 : (sel_tt ^ {TTW{inv_q}});
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and outputs; FIN drives the result straight out so done
  // and tt_out are valid in the same cycle.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    too_many  = 32'(num_gates) > MAX_GATES;
    last_gate = (32'(k_q) + 1) == 32'(ng_q);
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = rej_q;
    err       = err_q;
    tt_out    = tt_q;
    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (start) begin
          if (too_many) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = (num_gates == '0) ? S_FIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (gate_bad || last_gate) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        err     = err_fin;
        tt_out  = fin_tt;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Run parameters, gate counter, sticky error and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      ng_q  <= '0;
      sel_q <= '0;
      inv_q <= 1'b0;
      err_q <= 1'b0;
      rej_q <= 1'b0;
      tt_q  <= '0;
    end else begin
      rej_q <= reject;
      if (reject) begin
        err_q <= 1'b1;
        tt_q  <= '0;
      end
      if (accept) begin
        ng_q  <= num_gates;
        sel_q <= out_sel;
        inv_q <= out_inv;
        k_q   <= '0;
        err_q <= 1'b0;
        tt_q  <= '0;
      end
      if (state_q == S_RUN) begin
        if (gate_bad) begin
          err_q <= 1'b1;
        end
        k_q <= k_q + 1'b1;
      end
      if (state_q == S_FIN) begin
        tt_q  <= fin_tt;
        err_q <= err_fin;
      end
    end
  end

`ifdef MIG_SIM_NPN_EN
  // Projection negation mask, latched with the other run parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= '0;
    end else if (accept) begin
      neg_q <= in_neg;
    end
  end
`else
  assign neg_q = '0;
`endif

endmodule

// File: tb/tb_mig_tt_sim.sv
// Testbench for mig_tt_sim: expected results are queued when a run is issued
// and a monitor compares them when done pulses.
module tb_mig_tt_sim;

  localparam int NIN  = 4;
  localparam int MAXG = 16;
  localparam int IDXW = 5;
  localparam int TTW  = 16;
  localparam int OPW  = 3*(IDXW+1);
  localparam int AW   = 4;
  localparam int NGW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [AW-1:0]   cfg_addr = '0;
  logic [OPW-1:0]  cfg_wdata = '0;
  logic [NGW-1:0]  num_gates = '0;
  logic [IDXW-1:0] out_sel = '0;
  logic            out_inv = 1'b0;
`ifdef MIG_SIM_NPN_EN
  logic [NIN-1:0]  in_neg = '0;
`endif
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            err;
  logic [TTW-1:0]  tt_out;

  typedef struct {
    logic [TTW-1:0] tt;
    bit             e;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  logic [OPW-1:0] prog_m [MAXG];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;

  mig_tt_sim #(.NIN(NIN), .MAX_GATES(MAXG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .num_gates(num_gates), .out_sel(out_sel), .out_inv(out_inv),
`ifdef MIG_SIM_NPN_EN
    .in_neg(in_neg),
`endif
    .start(start), .busy(busy), .done(done), .err(err), .tt_out(tt_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Reference: evaluate minterm by minterm, majority = at least two of three.
  function automatic void model(input int ng, input int sel, input bit inv, input int neg,
                                output logic [TTW-1:0] tt, output bit e, output int lat);
    bit             val [0:NIN+MAXG][0:TTW-1];
    int             op [3];
    bit             iv [3];
    int             s;
    logic [OPW-1:0] w;
    tt = '0; e = 1'b0; lat = ng + 1;
    if (ng > MAXG) begin e = 1'b1; lat = 1; return; end
    for (int n = 0; n <= NIN+MAXG; n++)
      for (int m = 0; m < TTW; m++) val[n][m] = 1'b0;
    for (int i = 0; i < NIN; i++)
      for (int m = 0; m < TTW; m++)
        val[1+i][m] = (((m >> i) & 1) != 0) != (((neg >> i) & 1) != 0);
    for (int g = 0; g < ng; g++) begin
      w = prog_m[g];
      for (int k = 0; k < 3; k++) begin
        op[k] = int'(w[k*(IDXW+1) +: IDXW]);
        iv[k] = w[k*(IDXW+1) + IDXW];
        if (op[k] >= NIN + 1 + g) begin e = 1'b1; lat = g + 2; return; end
      end
      for (int m = 0; m < TTW; m++) begin
        s = 0;
        for (int k = 0; k < 3; k++) if (val[op[k]][m] != iv[k]) s++;
        val[NIN+1+g][m] = (s >= 2);
      end
    end
    if (sel >= NIN + 1 + ng) begin e = 1'b1; return; end
    for (int m = 0; m < TTW; m++) tt[m] = val[sel][m] ^ inv;
  endfunction

  function automatic logic [OPW-1:0] pk(input int o0, input int i0, input int o1,
                                        input int i1, input int o2, input int i2);
    return {1'(i2), IDXW'(o2), 1'(i1), IDXW'(o1), 1'(i0), IDXW'(o0)};
  endfunction

  function automatic logic [OPW-1:0] rand_gate(input int g);
    int o [3];
    for (int k = 0; k < 3; k++)
      o[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, NIN + g));
    return pk(o[0], int'($urandom_range(0, 1)), o[1], int'($urandom_range(0, 1)),
              o[2], int'($urandom_range(0, 1)));
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending run", cyc);
      end else begin
        x = sb.pop_front();
        chk("tt_out", 32'(tt_out), 32'(x.tt));
        chk("err", 32'(err), 32'(x.e));
        chk("done_cycle", cyc, x.cyc);
      end
    end
  end

  task automatic cfg_write(input int addr, input logic [OPW-1:0] data);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = AW'(addr); cfg_wdata = data;
    prog_m[addr] = data;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input int ng, input int sel, input bit inv, input int neg,
                       input bit do_cfg, input int addr, input logic [OPW-1:0] data,
                       input bit junk, input bit use_k, input logic [TTW-1:0] k_tt, input bit k_e);
    logic [TTW-1:0] t;
    bit             e;
    int             lat;
    @(negedge clk);
    if (do_cfg) begin
      cfg_valid = 1'b1; cfg_addr = AW'(addr); cfg_wdata = data;
      prog_m[addr] = data;
    end
    num_gates = NGW'(ng); out_sel = IDXW'(sel); out_inv = inv;
`ifdef MIG_SIM_NPN_EN
    in_neg = NIN'(neg);
`endif
    start = 1'b1;
    model(ng, sel, inv, neg, t, e, lat);
    if (use_k) begin t = k_tt; e = k_e; end
    sb.push_back('{tt: t, e: e, cyc: cyc + lat});
    @(negedge clk);
    start = 1'b0; cfg_valid = 1'b0;
    if (junk && ng <= MAXG) begin
      // Busy or finishing: neither of these may take effect.
      start = 1'b1; num_gates = NGW'($urandom); out_sel = IDXW'($urandom);
      out_inv = 1'($urandom);
      cfg_valid = 1'b1; cfg_addr = AW'($urandom); cfg_wdata = OPW'($urandom);
      @(negedge clk);
      start = 1'b0; cfg_valid = 1'b0;
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int ng, sel, neg;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_tt", 32'(tt_out), 0);
    chk("reset_cfg_ready", 32'(cfg_ready), 1);

    // MAJ(x0,x1,x2)
    cfg_write(0, pk(1, 0, 2, 0, 3, 0));
    issue(1, 5, 0, 0, 0, 0, '0, 0, 1, 16'hE8E8, 0);

    // x0 xor x1 built from three gates, plain and inverted
    cfg_write(0, pk(0, 0, 1, 0, 2, 0));
    cfg_write(1, pk(0, 1, 1, 0, 2, 0));
    cfg_write(2, pk(0, 0, 5, 1, 6, 0));
    issue(3, 7, 0, 0, 0, 0, '0, 0, 1, 16'h6666, 0);
    issue(3, 7, 1, 0, 0, 0, '0, 1, 1, 16'h9999, 0);

    // Projection only
    issue(0, 3, 0, 0, 0, 0, '0, 0, 1, 16'hF0F0, 0);

    // Self reference in gate 1, then a clean run clears err
    cfg_write(0, pk(1, 0, 2, 0, 3, 0));
    cfg_write(1, pk(6, 0, 1, 0, 2, 0));
    issue(2, 6, 0, 0, 0, 0, '0, 1, 1, 16'h0000, 1);
    issue(1, 5, 0, 0, 0, 0, '0, 0, 1, 16'hE8E8, 0);

    // Too many gates, then selection past the last evaluated gate
    issue(17, 5, 0, 0, 0, 0, '0, 0, 1, 16'h0000, 1);
    issue(1, 6, 0, 0, 0, 0, '0, 0, 1, 16'h0000, 1);

    // Write concurrent with start is seen by that run
    issue(1, 5, 0, 0, 1, 0, pk(1, 0, 2, 0, 0, 1), 0, 1, 16'hEEEE, 0);

`ifdef MIG_SIM_NPN_EN
    cfg_write(0, pk(0, 0, 1, 0, 2, 0));
    issue(1, 5, 0, 1, 0, 0, '0, 0, 1, 16'h4444, 0);
`endif

    // Reset mid-run: aborted without done, program survives
    for (int g = 0; g < 10; g++)
      cfg_write(g, pk($urandom_range(0, NIN + g), $urandom_range(0, 1),
                      $urandom_range(0, NIN + g), $urandom_range(0, 1),
                      $urandom_range(0, NIN + g), $urandom_range(0, 1)));
    issue(10, NIN + 10, 0, 0, 0, 0, '0, 0, 0, '0, 0);
    @(negedge clk);
    num_gates = NGW'(10); out_sel = IDXW'(NIN + 10); out_inv = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_busy", 32'(busy), 0);
    chk("midrun_rst_done", 32'(done), 0);
    chk("midrun_rst_tt", 32'(tt_out), 0);
    chk("midrun_rst_err", 32'(err), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(10, NIN + 10, 0, 0, 0, 0, '0, 0, 0, '0, 0);

    // Randomised programs and runs
    for (int g = 0; g < MAXG; g++) cfg_write(g, rand_gate(g));
    for (int r = 0; r < 40; r++) begin
      int a;
      ng  = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, MAXG)) : int'($urandom_range(MAXG + 1, 31));
      sel = ($urandom_range(0, 9) < 7 && ng <= MAXG) ? int'($urandom_range(0, NIN + ng)) : int'($urandom_range(0, 31));
`ifdef MIG_SIM_NPN_EN
      neg = int'($urandom_range(0, 15));
`else
      neg = 0;
`endif
      a = int'($urandom_range(0, MAXG - 1));
      issue(ng, sel, 1'($urandom), neg, ($urandom_range(0, 9) < 3), a, rand_gate(a),
            1'($urandom), 0, '0, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mig_tt_sim.md
Name: mig_tt_sim

Overview:
- Sequential, parametrised majority-inverter-graph (MIG) evaluator for the exact-synthesis flow.
- Holds a small MIG program of up to MAX_GATES three-input majority gates, each operand with an optional complement.
- Evaluates the program one gate per cycle over full NIN-input truth tables, bit-parallel, and returns the truth table of a selected node.
- Used to check candidate NPN-class implementations in hardware rather than by hand-written combinational netlists.

Parameters:
- NIN, 4, number of primary inputs (2..6); TTW = 2**NIN is a derived localparam, not overridable.
- MAX_GATES, 16, program memory depth (number of majority gates).
- IDXW, 5, node index width; must satisfy 2**IDXW >= 1+NIN+MAX_GATES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  program-write request.
- cfg_ready  out  1  high only in IDLE; a write occurs when cfg_valid && cfg_ready.
- cfg_addr  in  clog2(MAX_GATES)  gate slot being written.
- cfg_wdata  in  3*(IDXW+1)  packed {inv2,op2,inv1,op1,inv0,op0}; invK complements operand K.
- num_gates  in  clog2(MAX_GATES+1)  gates to evaluate; sampled at start.
- out_sel  in  IDXW  node index to output; sampled at start.
- out_inv  in  1  complement the output; sampled at start.
- start  in  1  run request; honoured only in IDLE.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse when a result or error is final.
- err  out  1  sticky error flag; cleared by the next accepted start.
- tt_out  out  TTW  result truth table; held until the next accepted start.

Behaviour:
- Node numbering:
  - 0 = constant 0.
  - 1..NIN = projections x0..x(NIN-1); bit m of xi's table is (m>>i)&1.
  - NIN+1+g = gate g.
- Gate g computes bitwise MAJ(a,b,c) = ab|ac|bc over TTW bits, with each operand XORed with its inv bit replicated.
- Reset: FSM to IDLE; busy=0, done=0, err=0, tt_out=0, all node registers cleared. Program memory is not cleared and stays valid.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start with num_gates <= MAX_GATES latches num_gates, out_sel and out_inv, clears err, and goes to RUN (or to FIN if num_gates=0).
  - start with num_gates > MAX_GATES sets err, pulses done next cycle, and stays IDLE.
- RUN:
  - Cycle k evaluates gate k and writes its node register.
  - Any operand index >= NIN+1+k (forward or self reference, or out of range) sets err and goes to FIN immediately; remaining gates are not evaluated.
  - After gate num_gates-1, go to FIN.
- FIN (one cycle):
  - tt_out = node[out_sel] ^ {TTW{out_inv}}; done=1; return to IDLE.
  - If out_sel >= NIN+1+num_gates, or err is set, then err=1 and tt_out=0.
- Latency: start accepted at cycle 0, done at cycle num_gates+1; busy high for cycles 1..num_gates.
- Concurrency and reset:
  - start during RUN or FIN is ignored.
  - cfg writes during RUN or FIN are impossible (cfg_ready=0).
  - start and cfg_valid together in IDLE: the write and the start both take effect, and the written gate is visible to that run.
  - rst mid-RUN aborts the run with no done pulse; tt_out=0.

Optional Feature:
- Macro MIG_SIM_NPN_EN.
- When defined:
  - Adds input port in_neg [NIN-1:0], sampled at start.
  - Projection xi is complemented when in_neg[i]=1, so input-negated NPN variants can be evaluated without reprogramming.
- When undefined: the port is absent and projections are plain.

Test Plan:
- NIN=4, one gate MAJ(x0,x1,x2), out_sel=5, start -> done at cycle 2, tt_out=16'hE8E8, err=0.
- Three gates: g0=MAJ(0,x0,x1), g1=MAJ(~0,x0,x1), g2=MAJ(0,~g0,g1); out_sel=7 -> done at cycle 4, tt_out=16'h6666; same run with out_inv=1 -> 16'h9999.
- num_gates=0, out_sel=3 (x2) -> done at cycle 1, tt_out=16'hF0F0.
- Gate 1 operand references node 6 (itself) -> err=1, done pulses, tt_out=0; next valid start clears err.
- Assert rst during RUN of a 10-gate program -> busy=0, no done pulse; rerun without reloading gives the same tt_out as before reset.
- With MIG_SIM_NPN_EN, in_neg=4'b0001, program MAJ(0,x0,x1) -> tt_out=16'h4444.
